// File: rtl/cic_interpolator.sv
// Four-stage CIC interpolator: low-rate comb section, zero-stuffing, high-rate integrators.
// Optional rounding/saturating output stage enabled by defining CIC_INT_ROUND_EN.
module cic_interpolator #(
   parameter int bit_width           = 20,
   parameter int interpolation_ratio = 16
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              in_valid,
   input  logic signed [7:0] in,
   output logic              in_ready,
   output logic              out_valid,
   output logic signed [7:0] out,
   output logic              underrun
);
   localparam int         shift     = bit_width - 8;
   localparam logic [7:0] count_max = 8'(interpolation_ratio - 1);

   logic [7:0]                  count_r;
   logic                        accept_s;
   logic                        load_r;
   logic [4:0]                  valid_pipe_r;
   logic signed [bit_width-1:0] z_r [1:4];
   logic signed [bit_width-1:0] c_s [0:4];
   logic signed [bit_width-1:0] cz_r;
   logic signed [bit_width-1:0] u_s;
   logic signed [bit_width-1:0] i_r [1:4];
   logic signed [7:0]           out_s;

`ifdef CIC_INT_ROUND_EN
   localparam logic signed [bit_width:0] round_half = (bit_width + 1)'(64'sd1 <<< (shift - 1));
   logic signed [bit_width:0]   rnd_sum_s;
   logic signed [8:0]           rnd_q_s;
`endif

   assign accept_s = (count_r == 8'd0);
   assign in_ready = accept_s & reset_n;

   // Comb differences on the sample presented at the accept edge, plus zero-stuffed integrator input.
   always_comb begin
      if (in_valid) begin
         c_s[0] = {{(bit_width - 8){in[7]}}, in};
      end else begin
         c_s[0] = {bit_width{1'b0}};
      end
      for (int k = 1; k <= 4; k++) begin
         c_s[k] = c_s[k-1] - z_r[k];
      end
      if (load_r) begin
         u_s = cz_r;
      end else begin
         u_s = {bit_width{1'b0}};
      end
   end

   // Phase counter, low-rate comb registers, handshake status.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count_r      <= 8'd0;
         load_r       <= 1'b0;
         valid_pipe_r <= 5'd0;
         out_valid    <= 1'b0;
         underrun     <= 1'b0;
         cz_r         <= {bit_width{1'b0}};
         for (int k = 1; k <= 4; k++) begin
            z_r[k] <= {bit_width{1'b0}};
         end
      end else begin
         count_r      <= (count_r == count_max) ? 8'd0 : count_r + 8'd1;
         load_r       <= accept_s;
         valid_pipe_r <= {valid_pipe_r[3:0], valid_pipe_r[0] | accept_s};
         out_valid    <= out_valid | valid_pipe_r[4];
         if (accept_s) begin
            for (int k = 1; k <= 4; k++) begin
               z_r[k] <= c_s[k-1];
            end
            cz_r <= c_s[4];
            if (!in_valid) begin
               underrun <= 1'b1;
            end
         end
      end
   end

   // Output scaling by R^3; the rounding build adds half an LSB and clips the top end.
   always_comb begin
`ifdef CIC_INT_ROUND_EN
      rnd_sum_s = {i_r[4][bit_width-1], i_r[4]} + round_half;
      rnd_q_s   = 9'(rnd_sum_s >>> shift);
      if (rnd_q_s > 9'sd127) begin
         out_s = 8'sd127;
      end else begin
         out_s = rnd_q_s[7:0];
      end
`else
      out_s = 8'(i_r[4] >>> shift);
`endif
   end

   // High-rate integrator pipeline and registered output; wrap-around cancels by design.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int k = 1; k <= 4; k++) begin
            i_r[k] <= {bit_width{1'b0}};
         end
         out <= 8'sd0;
      end else begin
         i_r[1] <= i_r[1] + u_s;
         for (int k = 2; k <= 4; k++) begin
            i_r[k] <= i_r[k] + i_r[k-1];
         end
         out <= out_s;
      end
   end

endmodule

// File: tb/tb_cic_interpolator.sv
// Directed bench for cic_interpolator (R = 16, bit_width = 20); expected outputs come from
// hand-derived constants and a direct-form boxcar^4 FIR reference.
module tb_cic_interpolator;
   logic              clk;
   logic              reset_n;
   logic              in_valid;
   logic signed [7:0] din;
   logic              in_ready;
   logic              out_valid;
   logic signed [7:0] out_q;
   logic              underrun;

   int n_checks;
   int n_pass;
   int hh [0:63];
   int xs [0:15];
   int obs [0:199];

   cic_interpolator #(.bit_width(20), .interpolation_ratio(16)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .in_valid  (in_valid),
      .in        (din),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out       (out_q),
      .underrun  (underrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input int got, input int exp);
      n_checks++;
      if (got == exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   // Reference: i4 is the boxcar^4 convolution of the accepted samples, scaled by 2^12.
   function automatic int model_out(input int m);
      int y;
      int n;
      int r;
      if (m < 5) return 0;
      y = 0;
      for (int a = 0; a < 16; a++) begin
         n = m - 5 - 16 * a;
         if (n >= 0 && n <= 60) y += xs[a] * hh[n];
      end
`ifdef CIC_INT_ROUND_EN
      r = (y + 2048) >>> 12;
      if (r > 127) r = 127;
`else
      r = y >>> 12;
`endif
      return r;
   endfunction

   task automatic do_reset();
      reset_n  = 1'b0;
      in_valid = 1'b0;
      din      = 8'sd0;
      #1;
      check_eq("rst_out", out_q, 0);
      check_eq("rst_out_valid", out_valid, 0);
      check_eq("rst_underrun", underrun, 0);
      check_eq("rst_in_ready", in_ready, 0);
      @(posedge clk);
      #4;
      reset_n = 1'b1;
      #1;
      check_eq("rel_in_ready", in_ready, 1);
   endtask

   task automatic run_stream(input int n_edges, input int v0, input int vrest, input int drop_at);
      int a;
      int v;
      for (int i = 0; i < 16; i++) xs[i] = 0;
      for (int k = 0; k < n_edges; k++) begin
         if (k % 16 == 0) begin
            a   = k / 16;
            v   = (a == 0) ? v0 : vrest;
            din = 8'(v);
            if (a == drop_at) begin
               in_valid = 1'b0;
               xs[a]    = 0;
            end else begin
               in_valid = 1'b1;
               xs[a]    = v;
            end
         end else begin
            in_valid = (k % 3 == 0);
            din      = 8'sh55;
         end
         @(posedge clk);
         #1;
         obs[k] = out_q;
         check_eq($sformatf("out@%0d", k), out_q, model_out(k));
         check_eq($sformatf("in_ready@%0d", k), in_ready, int'((k + 1) % 16 == 0));
         check_eq($sformatf("out_valid@%0d", k), out_valid, int'(k >= 5));
         check_eq($sformatf("underrun@%0d", k), underrun, int'(drop_at >= 0 && k >= 16 * drop_at));
      end
   endtask

   initial begin
      int t [0:63];
      int len;
      int nz;
      n_checks = 0;
      n_pass   = 0;
      for (int i = 0; i < 64; i++) hh[i] = 0;
      hh[0] = 1;
      len   = 1;
      repeat (4) begin
         for (int i = 0; i < 64; i++) t[i] = 0;
         for (int i = 0; i < len; i++)
            for (int j = 0; j < 16; j++) t[i + j] += hh[i];
         len += 15;
         for (int i = 0; i < 64; i++) hh[i] = t[i];
      end

      reset_n  = 1'b1;
      in_valid = 1'b0;
      din      = 8'sd0;
      #2;

      // DC step of 64
      do_reset();
      run_stream(120, 64, 64, -1);
      for (int k = 0; k < 5; k++) check_eq($sformatf("dc_pre@%0d", k), obs[k], 0);
      for (int k = 69; k < 120; k++) check_eq($sformatf("dc64@%0d", k), obs[k], 64);

      // Negative full scale
      do_reset();
      run_stream(110, -128, -128, -1);
      for (int k = 0; k < 110; k++) check_eq($sformatf("neg_nowrap@%0d", k), int'(obs[k] > 0), 0);
      for (int k = 69; k < 110; k++) check_eq($sformatf("neg128@%0d", k), obs[k], -128);

      // Impulse of 127
      do_reset();
      run_stream(130, 127, 0, -1);
      check_eq("imp@7", obs[7], 0);
`ifdef CIC_INT_ROUND_EN
      check_eq("imp@8", obs[8], 1);
`else
      check_eq("imp@8", obs[8], 0);
`endif
      check_eq("imp@9", obs[9], 1);
      check_eq("imp@20", obs[20], 25);
      nz = 0;
      for (int k = 0; k < 130; k++) if (obs[k] != 0) nz++;
`ifdef CIC_INT_ROUND_EN
      check_eq("imp_len", nz, 55);
`else
      check_eq("imp_len", nz, 53);
`endif
      for (int k = 70; k < 130; k++) check_eq($sformatf("imp_tail@%0d", k), obs[k], 0);

      // Underrun at the third accept, then reset mid-stream
      do_reset();
      run_stream(130, 64, 64, 2);
      check_eq("ur_dip", int'(obs[60] < 64), 1);
      check_eq("ur_settled", obs[129], 64);
      do_reset();

      // Near positive full scale
      run_stream(100, 127, 127, -1);
      for (int k = 69; k < 100; k++) check_eq($sformatf("pos127@%0d", k), obs[k], 127);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
